// File: rtl/xmpl_dsp_stage_rsp.sv
// xmpl_dsp_stage_rsp: one response stage of the DSP chain (CIC/FFT/FLT).
// A rising edge on the enable starts a job of frame_len_i samples. The stage
// forwards samples through a single skid-free output register with 1-cycle
// latency, tags the final sample with m_last_o, then reports done status.
//
// Ports:
//   clk_i        - clock, all state on rising edge
//   reset_n_i    - asynchronous active-low reset
//   en_i         - stage enable from the sequencing FSM
//   frame_len_i  - samples per frame, sampled only at job start
//   s_valid_i / s_data_i / s_ready_o - upstream sample handshake
//   m_valid_o / m_data_o / m_last_o / m_ready_i - downstream sample handshake
//   status_o     - stage done
//   err_o        - job rejected (zero-length frame)
//   state_o      - current state encoding (debug)
module xmpl_dsp_stage_rsp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              status_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4,
    StErr   = 3'd5
  } state_e;

  state_e            r_state;
  logic              r_en;
  logic              r_seen_low;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic              r_status;
  logic              r_err;

  logic w_start;
  logic w_abort;
  logic w_s_ready;
  logic w_accept;
  logic w_out_hs;
  logic w_final;

  // r_seen_low blocks a start until en_i has been observed low after reset, so
  // an enable held high across reset release does not look like a rising edge.
  assign w_start   = en_i & ~r_en & r_seen_low;
  assign w_abort   = ~en_i & ((r_state == StArm) | (r_state == StRun) | (r_state == StDrain));
  assign w_s_ready = (r_state == StRun) & (~r_m_valid | m_ready_i);
  assign w_accept  = s_valid_i & w_s_ready;
  assign w_out_hs  = r_m_valid & m_ready_i;
  // len_q >= 1 whenever RUN is reached, so len_q-1 never underflows here.
  assign w_final   = (r_cnt == (r_len - LEN_W'(1)));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= StIdle;
      r_en       <= 1'b0;
      r_seen_low <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_last   <= 1'b0;
      r_status   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_en       <= en_i;
      r_seen_low <= r_seen_low | ~en_i;
      if (w_abort) begin
        // Pending output sample is dropped.
        r_state   <= StIdle;
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
        r_cnt     <= '0;
        r_status  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_status <= 1'b0;
            r_err    <= 1'b0;
            if (w_start) begin
              r_len <= frame_len_i;
              if (frame_len_i == '0) begin
                r_state <= StErr;
                r_err   <= 1'b1;
              end else begin
                r_state <= StArm;
              end
            end
          end
          StArm: begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_state   <= StRun;
          end
          StRun: begin
            if (w_accept) begin
              r_m_data  <= s_data_i;
              r_m_valid <= 1'b1;
              r_m_last  <= w_final;
              r_cnt     <= r_cnt + LEN_W'(1);
              if (w_final) begin
                r_state <= StDrain;
              end
            end else if (w_out_hs) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
            end
          end
          StDrain: begin
            if (w_out_hs && r_m_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_status  <= 1'b1;
              r_state   <= StDone;
            end
          end
          StDone: begin
            r_status <= 1'b1;
            if (!en_i) begin
              r_status <= 1'b0;
              r_state  <= StIdle;
            end
          end
          StErr: begin
            r_err    <= 1'b1;
            r_status <= 1'b0;
            if (!en_i) begin
              r_err   <= 1'b0;
              r_state <= StIdle;
            end
          end
          default: begin
            // Unreachable encodings recover to IDLE with a clean output side.
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_status  <= 1'b0;
            r_err     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s_ready_o = w_s_ready;
  assign m_valid_o = r_m_valid;
  assign m_data_o  = r_m_data;
  assign m_last_o  = r_m_last;
  assign status_o  = r_status;
  assign err_o     = r_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_xmpl_dsp_stage_rsp.sv
// Randomized scoreboard bench for xmpl_dsp_stage_rsp. The driver pushes the
// expected {last, data} of every accepted sample; a monitor pops on each output
// handshake and also checks stall stability.
module tb_xmpl_dsp_stage_rsp;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 10;

  logic              clk_i;
  logic              reset_n_i;
  logic              en_i;
  logic [LEN_W-1:0]  frame_len_i;
  logic              s_valid_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_ready_o;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;
  logic              m_ready_i;
  logic              status_o;
  logic              err_o;
  logic [2:0]        state_o;

  xmpl_dsp_stage_rsp #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .en_i        (en_i),
    .frame_len_i (frame_len_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .m_ready_i   (m_ready_i),
    .status_o    (status_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int out_cnt  = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [DATA_W:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return logic'($urandom_range(0, 1));
    return ((c % 4) == 0) || ((c % 4) == 3);  // 1,0,0,1 pattern
  endfunction

  // Monitor: scoreboard pop on output handshake plus stall invariants.
  always @(negedge clk_i) begin
    logic [DATA_W:0] e;
    if (mon_en && reset_n_i) begin
      if (prev_stall) chk("stall_hold", {15'd0, m_valid_o, m_data_o}, {15'd0, 1'b1, prev_data});
      if (m_valid_o && !m_ready_i) chk("stall_sready", 32'(s_ready_o), 32'd0);
      if (!m_valid_o) chk("last_without_valid", 32'(m_last_o), 32'd0);
      if (m_valid_o && m_ready_i) begin
        out_cnt++;
        chk("out_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", 32'(m_data_o), 32'(e[DATA_W-1:0]));
          chk("out_last", 32'(m_last_o), 32'(e[DATA_W]));
        end
      end
      prev_stall = m_valid_o & ~m_ready_i & en_i;
      prev_data  = m_data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Runs one job; abort_after > 0 drops en_i after that many accepted samples.
  task automatic run_frame(input int len, input int mode, input int abort_after);
    int acc = 0;
    int cyc = 0;
    int bound = 20 * len + 50;
    logic took;
    logic [DATA_W-1:0] d;
    out_cnt = 0;
    frame_len_i = LEN_W'(len);
    en_i = 1'b1;
    s_valid_i = 1'b0;
    m_ready_i = 1'b1;
    step();
    chk("arm_state", 32'(state_o), 32'd1);
    frame_len_i = LEN_W'($urandom);  // mid-job change must be ignored
    step();
    chk("run_state", 32'(state_o), 32'd2);
    while (acc < len && cyc < bound) begin
      s_valid_i = (mode == 1) ? logic'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = DATA_W'($urandom);
      m_ready_i = rdy(mode, cyc);
      frame_len_i = LEN_W'($urandom);
      @(negedge clk_i);
      took = s_valid_i & s_ready_o;
      d = s_data_i;
      if (took) begin
        acc++;
        exp_q.push_back({acc == len, d});
      end
      step();
      cyc++;
      if (took) chk("latency_1", {15'd0, m_valid_o, m_data_o}, {15'd0, 1'b1, d});
      if (abort_after > 0 && acc == abort_after) break;
    end
    s_valid_i = 1'b0;
    if (abort_after > 0) begin
      en_i = 1'b0;
      m_ready_i = 1'b0;
      step();
      chk("abort_state", 32'(state_o), 32'd0);
      chk("abort_mvalid", 32'(m_valid_o), 32'd0);
      chk("abort_mlast", 32'(m_last_o), 32'd0);
      chk("abort_status", 32'(status_o), 32'd0);
      exp_q.delete();
      m_ready_i = 1'b1;
      step();
      return;
    end
    chk("accepted_all", 32'(acc), 32'(len));
    while (status_o !== 1'b1 && cyc < bound) begin
      m_ready_i = rdy(mode, cyc);
      step();
      cyc++;
    end
    chk("done_status", 32'(status_o), 32'd1);
    chk("done_state", 32'(state_o), 32'd4);
    chk("frame_count", 32'(out_cnt), 32'(len));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    m_ready_i = 1'b1;
    step();
    chk("done_hold", 32'(status_o), 32'd1);
    en_i = 1'b0;
    step();
    chk("idle_after_done", 32'(state_o), 32'd0);
    chk("status_clear", 32'(status_o), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0;
    en_i = 1'b0;
    frame_len_i = '0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    m_ready_i = 1'b1;
    step();
    step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_outputs", {25'd0, s_ready_o, m_valid_o, m_last_o, status_o, err_o, 2'b00},
        32'd0);
    chk("rst_mdata", 32'(m_data_o), 32'd0);
    reset_n_i = 1'b1;
    step();
    step();
    mon_en = 1'b1;

    run_frame(4, 0, 0);
    run_frame(3, 2, 0);

    // Zero-length frame is rejected.
    frame_len_i = '0;
    en_i = 1'b1;
    s_valid_i = 1'b1;
    step();
    chk("err_state", 32'(state_o), 32'd5);
    chk("err_flag", 32'(err_o), 32'd1);
    chk("err_status", 32'(status_o), 32'd0);
    chk("err_sready", 32'(s_ready_o), 32'd0);
    step();
    chk("err_hold", 32'(err_o), 32'd1);
    s_valid_i = 1'b0;
    en_i = 1'b0;
    step();
    chk("err_exit_state", 32'(state_o), 32'd0);
    chk("err_exit_flag", 32'(err_o), 32'd0);

    run_frame(8, 0, 3);
    run_frame(8, 1, 0);

    // Asynchronous reset during RUN with a held output sample.
    mon_en = 1'b0;
    frame_len_i = 10'd8;
    en_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = DATA_W'($urandom) | DATA_W'(1);
    m_ready_i = 1'b0;
    for (int i = 0; i < 10 && m_valid_o !== 1'b1; i++) step();
    chk("rst_pre_valid", 32'(m_valid_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_outputs", {25'd0, s_ready_o, m_valid_o, m_last_o, status_o, err_o, 2'b00},
        32'd0);
    chk("arst_mdata", 32'(m_data_o), 32'd0);
    @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    m_ready_i = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en_high_stays_idle", 32'(state_o), 32'd0);
    end
    chk("en_high_no_sready", 32'(s_ready_o), 32'd0);
    s_valid_i = 1'b0;
    en_i = 1'b0;
    step();
    mon_en = 1'b1;

    run_frame(1, 0, 0);
    run_frame(1023, 0, 0);
    for (int k = 0; k < 4; k++) run_frame(int'($urandom_range(2, 20)), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
